booth_mult_sched: RTL and testbench

- Two-requester scheduler and sequencer for one shared signed WIDTHxWIDTH multiplier datapath.
- The datapath is an iterative radix-4 Booth engine that retires one Booth digit per cycle.
- Arbitrates round-robin between two clients, captures operands, and steps the engine through WIDTH/2 partial-product accumulations.
- Returns a tagged 2*WIDTH-bit product over a valid/ready output channel. Sits beside the combinational multiplier wherever area matters more than latency.

---
 rtl/booth_mult_sched.sv | 138 +++++++++++++
 tb/tb_booth_mult_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sched.sv
// rtl/booth_mult_sched.sv - two-client round-robin scheduler around an iterative radix-4 Booth multiplier
//
// Shares one signed WIDTH x WIDTH radix-4 Booth engine between two requesters.
// The engine retires one Booth digit per cycle, so one product takes WIDTH/2 cycles.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid[1:0]      per-client request valid (bit i = client i)
//   req_ready[1:0]      per-client accept, one-hot or zero, only in IDLE
//   req_x0/req_y0       client 0 multiplicand / multiplier (signed)
//   req_x1/req_y1       client 1 multiplicand / multiplier (signed)
//   out_valid/out_ready result handshake
//   out_o               signed 2*WIDTH-bit product
//   out_id              client that issued the result
//   busy                high while an operation is in flight or its result is unconsumed
module booth_mult_sched #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req_x0,
    input  logic [WIDTH-1:0]     req_y0,
    input  logic [WIDTH-1:0]     req_x1,
    input  logic [WIDTH-1:0]     req_y1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_o,
    output logic                 out_id,
    output logic                 busy
);

    localparam int PW   = 2 * WIDTH;
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic             id_q;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    // Multiplicand pre-shifted by 2k so the partial product needs no variable shifter.
    logic [PW-1:0]    x_sh;
    // Multiplier with the implicit y[-1]=0 appended; shifted right by 2 per digit,
    // so the current Booth triplet is always the low three bits.
    logic [WIDTH:0]   y_sh;

    logic             grant;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             accept;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_next;

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last_grant;
        else if (req_valid[1])
            grant = 1'b1;

        req_ready = 2'b00;
        if (state == S_IDLE && req_valid[grant])
            req_ready[grant] = 1'b1;

        accept = |req_ready;
        sel_x  = grant ? req_x1 : req_x0;
        sel_y  = grant ? req_y1 : req_y0;
    end

    always_comb begin
        pp = '0;
        case (y_sh[2:0])
            3'b001, 3'b010: pp = x_sh;
            3'b011:         pp = x_sh << 1;
            3'b100:         pp = -(x_sh << 1);
            3'b101, 3'b110: pp = -x_sh;
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            x_sh       <= '0;
            y_sh       <= '0;
            out_valid  <= 1'b0;
            out_o      <= '0;
            out_id     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_sh       <= {{WIDTH{sel_x[WIDTH-1]}}, sel_x};
                        y_sh       <= {sel_y, 1'b0};
                        id_q       <= grant;
                        last_grant <= grant;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc  <= acc_next;
                    x_sh <= x_sh << 2;
                    y_sh <= y_sh >> 2;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        out_o     <= acc_next;
                        out_id    <= id_q;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_sched.sv
// tb/tb_booth_mult_sched.sv - directed and randomized self-checking bench for booth_mult_sched
module tb_booth_mult_sched;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_x0, req_y0, req_x1, req_y1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_o;
    logic        out_id;
    logic        busy;

    int checks;
    int failures;

    booth_mult_sched #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_o     (out_o),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input int c, input logic [15:0] x, input logic [15:0] y,
                         output logic [1:0] rdy, output logic [31:0] prod,
                         output logic id, output int lat, output logic tmo);
        if (c == 0) begin
            req_x0 = x; req_y0 = y; req_valid = 2'b01;
        end else begin
            req_x1 = x; req_y1 = y; req_valid = 2'b10;
        end
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = 2'b00;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tmo  = !out_valid;
        prod = out_o;
        id   = out_id;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b1;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, out_valid, out_o, out_id, busy} !== 37'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b o=%h id=%b busy=%b required all zero",
                     req_ready, out_valid, out_o, out_id, busy);
        end
    endtask

    task automatic test_basic();
        logic [1:0]  rdy;
        logic [31:0] prod;
        logic        id, tmo;
        int          lat;
        out_ready = 1'b1;
        do_op(0, 16'd3, 16'd5, rdy, prod, id, lat, tmo);
        checks++;
        if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout: no out_valid within 40 cycles"); end
        checks++;
        if (rdy !== 2'b01) begin failures++; $display("FAIL basic_ready: got %b required 01", rdy); end
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d required 9", lat); end
        checks++;
        if (prod !== 32'h0000000F) begin failures++; $display("FAIL basic_product: got %h required 0000000f", prod); end
        checks++;
        if (id !== 1'b0) begin failures++; $display("FAIL basic_id: got %b required 0", id); end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_after: busy=%b valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_client1();
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        logic [31:0] es [3];
        logic [1:0]  rdy;
        logic [31:0] prod;
        logic        id, tmo;
        int          lat;
        xs = '{16'hFFF9, 16'h8000, 16'h7FFF};
        ys = '{16'h0009, 16'h8000, 16'h8000};
        es = '{32'hFFFFFFC1, 32'h40000000, 32'hC0008000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(1, xs[i], ys[i], rdy, prod, id, lat, tmo);
            checks++;
            if (tmo !== 1'b0 || lat !== 9) begin
                failures++;
                $display("FAIL c1_latency[%0d]: got %0d timeout=%b required 9", i, lat, tmo);
            end
            checks++;
            if (rdy !== 2'b10) begin failures++; $display("FAIL c1_ready[%0d]: got %b required 10", i, rdy); end
            checks++;
            if (prod !== es[i]) begin failures++; $display("FAIL c1_product[%0d]: got %h required %h", i, prod, es[i]); end
            checks++;
            if (id !== 1'b1) begin failures++; $display("FAIL c1_id[%0d]: got %b required 1", i, id); end
        end
    endtask

    task automatic test_fairness();
        logic        grants  [4];
        logic [31:0] results [4];
        logic        ids     [4];
        logic        saw_both;
        int          ng, nr, cyc;
        logic [31:0] exp_r;
        apply_reset();
        saw_both = 1'b0;
        ng = 0; nr = 0; cyc = 0;
        req_x0 = 16'd2; req_y0 = 16'd3;
        req_x1 = 16'd4; req_y1 = 16'd5;
        req_valid = 2'b11;
        while (nr < 4 && cyc < 200) begin
            #1;
            if (req_ready == 2'b11) saw_both = 1'b1;
            if (req_ready != 2'b00 && ng < 4) begin
                grants[ng] = req_ready[1];
                ng++;
            end
            if (out_valid) begin
                results[nr] = out_o;
                ids[nr]     = out_id;
                nr++;
                if (nr == 4) req_valid = 2'b00;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 2'b00;
        checks++;
        if (nr !== 4 || ng !== 4) begin
            failures++;
            $display("FAIL fair_count: results=%0d grants=%0d required 4 4", nr, ng);
        end
        checks++;
        if (saw_both !== 1'b0) begin failures++; $display("FAIL fair_onehot: req_ready seen 11 required never"); end
        for (int i = 0; i < 4; i++) begin
            if (i < ng && i < nr) begin
                exp_r = (i % 2 == 0) ? 32'd6 : 32'd20;
                checks++;
                if (grants[i] !== 1'(i % 2) || ids[i] !== 1'(i % 2) || results[i] !== exp_r) begin
                    failures++;
                    $display("FAIL fair_seq[%0d]: grant=%b id=%b result=%0d required %0d %0d %0d",
                             i, grants[i], ids[i], results[i], i % 2, i % 2, exp_r);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b0;
        req_x0 = 16'd6; req_y0 = 16'd7;
        req_valid = 2'b01;
        @(negedge clk);
        req_x1 = 16'd2; req_y1 = 16'd2;
        req_valid = 2'b10;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout: out_valid=%b required 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_o !== 32'd42 || out_id !== 1'b0 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b o=%0d id=%b ready=%b required 1 42 0 00",
                         i, out_valid, out_o, out_id, req_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_handshake_cycle: ready=%b required 00", req_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b10 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept: ready=%b valid=%b required 10 0", req_ready, out_valid);
        end
        @(negedge clk);
        req_valid = 2'b00;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
        checks++;
        if (out_valid !== 1'b1 || out_o !== 32'd4 || out_id !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: valid=%b o=%0d id=%b required 1 4 1", out_valid, out_o, out_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        logic        seen;
        logic [1:0]  rdy;
        logic [31:0] prod;
        logic        id, tmo;
        int          lat;
        out_ready = 1'b1;
        req_x0 = 16'd10; req_y0 = 16'd10;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midreset_discard: valid/busy seen=%b required 0", seen); end
        do_op(0, 16'hFFFF, 16'hFFFF, rdy, prod, id, lat, tmo);
        checks++;
        if (tmo !== 1'b0 || lat !== 9 || prod !== 32'h00000001 || id !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next: lat=%0d o=%h id=%b timeout=%b required 9 00000001 0 0",
                     lat, prod, id, tmo);
        end
    endtask

    task automatic test_random();
        int          c, cyc, e;
        logic [15:0] x, y;
        logic        got;
        logic [31:0] prod;
        logic        id;
        for (int n = 0; n < 1000; n++) begin
            c = $urandom_range(0, 1);
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) x = 16'h8000;
            if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
            e = int'($signed(x)) * int'($signed(y));
            req_x0 = 16'($urandom); req_y0 = 16'($urandom);
            req_x1 = 16'($urandom); req_y1 = 16'($urandom);
            if (c == 0) begin req_x0 = x; req_y0 = y; req_valid = 2'b01; end
            else        begin req_x1 = x; req_y1 = y; req_valid = 2'b10; end
            cyc = 0;
            #1;
            while (req_ready[c] !== 1'b1 && cyc < 40) begin @(negedge clk); #1; cyc++; end
            @(negedge clk);
            req_valid = 2'b00;
            req_x0 = 16'($urandom); req_y0 = 16'($urandom);
            req_x1 = 16'($urandom); req_y1 = 16'($urandom);
            got = 1'b0; cyc = 0;
            prod = '0; id = 1'b0;
            while (!got && cyc < 100) begin
                if (out_valid) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_ready) begin
                        got = 1'b1; prod = out_o; id = out_id;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            out_ready = 1'b1;
            checks++;
            if (!got || prod !== 32'(e) || id !== 1'(c)) begin
                failures++;
                $display("FAIL rand[%0d]: x=%h y=%h got=%b o=%h id=%b required %h %0d",
                         n, x, y, got, prod, id, 32'(e), c);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_client1();
        test_fairness();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
